// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider controller.
// The optional tick counter is enabled by defining CLK_DIV_TICK_CNT_EN.
package clk_div_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int TICK_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // Saturating increment for the tick counter; holds at all-ones.
  function automatic logic [TICK_CNT_W-1:0] sat_inc(input logic [TICK_CNT_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider counter: counts up while run is high, clears on terminal count,
// and is held at zero when not running.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] count_q, count_d;

  assign term  = (count_q == term_val);
  assign count = count_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q + 1'b1;
    if (!run || term) count_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time clock-divider controller: FSM, config handshake, divided clock and tick counter.
// Define CLK_DIV_TICK_CNT_EN to build the saturating tick counter; otherwise tick_count is 0.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 12499
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cfg_valid,
  input  logic [CNT_W-1:0]      cfg_div,
  output logic                  cfg_ready,
  output logic                  tick,
  output logic                  divided_clk,
  output logic                  busy,
  output logic [TICK_CNT_W-1:0] tick_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             dclk_q, dclk_d;
  logic [CNT_W-1:0] count;
  logic             term;
  logic             run;
  logic             xfer;

  // Counter stops (and clears) the cycle en drops, so IDLE is entered with count=0.
  assign run  = (state_q != IDLE) && en;
  assign xfer = cfg_valid && cfg_ready;

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk_in   (clk_in),
    .rst      (rst),
    .run      (run),
    .term_val (div_q),
    .count    (count),
    .term     (term)
  );

  assign tick        = (state_q != IDLE) && term;
  assign cfg_ready   = (state_q != PEND);
  assign busy        = (state_q == PEND);
  assign divided_clk = dclk_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pend_d  = pend_q;
    dclk_d  = dclk_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) div_d = cfg_div;
        if (en)   state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          dclk_d  = 1'b0;
          if (xfer) div_d = cfg_div;
        end else begin
          if (tick) dclk_d = ~dclk_q;
          if (xfer) begin
            pend_d  = cfg_div;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // A pending value is never lost: it commits either at the terminal count or on stop.
        if (!en) begin
          state_d = IDLE;
          dclk_d  = 1'b0;
          div_d   = pend_q;
        end else if (tick) begin
          state_d = RUN;
          dclk_d  = ~dclk_q;
          div_d   = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= CNT_W'(DEFAULT_DIV);
      pend_q  <= '0;
      dclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      dclk_q  <= dclk_d;
    end
  end

`ifdef CLK_DIV_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst)       tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= sat_inc(tick_cnt_q);
  end

  assign tick_count = tick_cnt_q;
`else
  assign tick_count = '0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed table, hand sequences for the corner
// cases, and randomized traffic against a cycle-level behavioural model.
module tb_clk_div_ctrl;

  localparam int          CNT_W = 32;
  localparam logic [31:0] DEF   = 32'd3;

  logic             clk_in = 1'b0;
  logic             rst, en, cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready, tick, divided_clk, busy;
  logic [15:0]      tick_count;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .tick        (tick),
    .divided_clk (divided_clk),
    .busy        (busy),
    .tick_count  (tick_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: running flag, phase within the period, active divide value,
  // a queue holding at most one waiting config, divided clock level, tick tally.
  bit          m_run;
  logic [31:0] m_cnt, m_div;
  logic [31:0] m_pend[$];
  bit          m_dclk;
  int          m_ticks;

  function automatic bit m_tick();
    return m_run && (m_cnt == m_div);
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_div = DEF; m_pend.delete(); m_dclk = 0; m_ticks = 0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit v, input logic [31:0] d);
    bit t, x;
    t = m_tick();
    x = v && (m_pend.size() == 0);
    if (r) model_reset();
    else begin
`ifdef CLK_DIV_TICK_CNT_EN
      if (t && m_ticks < 65535) m_ticks++;
`endif
      if (!m_run) begin
        if (x) m_div = d;
        m_cnt = 0;
        m_run = e;
      end else if (!e) begin
        if (m_pend.size() != 0) m_div = m_pend.pop_front();
        if (x) m_div = d;
        m_run = 0; m_cnt = 0; m_dclk = 0;
      end else begin
        if (t) begin
          m_dclk = !m_dclk;
          m_cnt  = 0;
          if (m_pend.size() != 0) m_div = m_pend.pop_front();
        end else m_cnt++;
        if (x) m_pend.push_back(d);
      end
    end
  endtask

  bit s_tick, s_ready, s_busy, s_dclk;

  // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
  task automatic cycle(input bit r, input bit e, input bit v, input logic [31:0] d);
    rst = r; en = e; cfg_valid = v; cfg_div = d;
    @(negedge clk_in);
    check("tick",        32'(tick),        32'(m_tick()));
    check("cfg_ready",   32'(cfg_ready),   32'(m_pend.size() == 0));
    check("busy",        32'(busy),        32'(m_pend.size() != 0));
    check("divided_clk", 32'(divided_clk), 32'(m_dclk));
    check("tick_count",  32'(tick_count),  32'(m_ticks[15:0]));
    s_tick = tick; s_ready = cfg_ready; s_busy = busy; s_dclk = divided_clk;
    @(posedge clk_in);
    model_step(r, e, v, d);
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0);
  endtask

  typedef struct {
    bit exp_tick;
    bit exp_dclk;
    bit exp_ready;
    bit exp_busy;
  } vec_t;

  vec_t vt[14];

  initial begin
    for (int c = 0; c < 14; c++) begin
      vt[c].exp_tick  = (c != 0) && (c % 4 == 0);
      vt[c].exp_dclk  = (c == 0) ? 1'b0 : 1'(((c - 1) / 4) % 2);
      vt[c].exp_ready = 1'b1;
      vt[c].exp_busy  = 1'b0;
    end

    rst = 1; en = 0; cfg_valid = 0; cfg_div = '0;
    repeat (2) @(posedge clk_in);
    model_reset();
    #1;

    // Reset state
    rst = 0;
    @(negedge clk_in);
    check("rst_tick", 32'(tick), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_dclk", 32'(divided_clk), 0);
    check("rst_tick_count", 32'(tick_count), 0);
    @(posedge clk_in); #1;
    do_reset();

    // Test 1: default divide 3, en from cycle 0
    for (int c = 0; c < 14; c++) begin
      cycle(0, 1, 0, 0);
      check($sformatf("t1_tick[%0d]", c),  32'(s_tick),  32'(vt[c].exp_tick));
      check($sformatf("t1_dclk[%0d]", c),  32'(s_dclk),  32'(vt[c].exp_dclk));
      check($sformatf("t1_ready[%0d]", c), 32'(s_ready), 32'(vt[c].exp_ready));
      check($sformatf("t1_busy[%0d]", c),  32'(s_busy),  32'(vt[c].exp_busy));
    end

    // Test 2: cfg 1 offered at count=1 while running with div 3
    do_reset();
    cycle(0, 1, 0, 0);                     // IDLE
    cycle(0, 1, 0, 0);                     // count 0
    cycle(0, 1, 1, 1);                     // count 1, transfer
    check("t2_ready_xfer", 32'(s_ready), 1);
    cycle(0, 1, 0, 0);                     // count 2
    check("t2_ready_pend", 32'(s_ready), 0);
    check("t2_busy_pend", 32'(s_busy), 1);
    cycle(0, 1, 0, 0);                     // count 3, terminal
    check("t2_tick_term", 32'(s_tick), 1);
    check("t2_busy_term", 32'(s_busy), 1);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 0, 0);
      check($sformatf("t2_tick_new[%0d]", k), 32'(s_tick), 32'(k % 2));
      check($sformatf("t2_busy_new[%0d]", k), 32'(s_busy), 0);
    end

    // Test 3: divide 0 set in IDLE
    do_reset();
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, 0);
      check($sformatf("t3_tick[%0d]", k), 32'(s_tick), 1);
      check($sformatf("t3_dclk[%0d]", k), 32'(s_dclk), 32'(k % 2));
    end

    // Test 4: en dropped in PEND (div 2, pend 5)
    do_reset();
    cycle(0, 0, 1, 2);
    cycle(0, 1, 0, 0);                     // IDLE
    cycle(0, 1, 1, 5);                     // count 0, transfer -> PEND
    cycle(0, 0, 0, 0);                     // PEND, en low
    check("t4_busy_before", 32'(s_busy), 1);
    cycle(0, 0, 0, 0);                     // IDLE
    check("t4_tick_idle", 32'(s_tick), 0);
    check("t4_ready_idle", 32'(s_ready), 1);
    check("t4_busy_idle", 32'(s_busy), 0);
    check("t4_dclk_idle", 32'(s_dclk), 0);
    cycle(0, 1, 0, 0);                     // IDLE -> RUN
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 0, 0);
      check($sformatf("t4_period6[%0d]", k), 32'(s_tick), 32'(k == 5));
    end

    // Test 5: reset mid-RUN with a pending config
    do_reset();
    cycle(0, 0, 1, 7);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 2);                     // now PEND
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("t5_tick", 32'(s_tick), 0);
    check("t5_ready", 32'(s_ready), 1);
    check("t5_busy", 32'(s_busy), 0);
    check("t5_dclk", 32'(s_dclk), 0);
    check("t5_tick_count", 32'(tick_count), 0);
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, 0);
      check($sformatf("t5_default_period[%0d]", k), 32'(s_tick), 32'(k == 3));
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
            ($urandom_range(0, 4) == 0), 32'($urandom_range(0, 6)));
    end

    // Test 6: tick counter saturation with divide 0
    do_reset();
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 70000; i++) cycle(0, 1, 0, 0);
`ifdef CLK_DIV_TICK_CNT_EN
    check("t6_tick_count_sat", 32'(tick_count), 32'hFFFF);
`else
    check("t6_tick_count_zero", 32'(tick_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
